// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (LSB first, one full-adder cell, registered carry).
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_c;
  logic last_bit;

  assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign last_bit = (cnt_q == LAST_BIT);

  // State register plus datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; sum fills from the MSB so it is aligned after WIDTH shifts
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = cin_i;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          cout_d = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d  = carry_q ^ fa_c;
`endif
        end
      end
      S_DONE: begin
`ifdef SERIAL_ADD_OVF_EN
        if (out_ready_i) ovf_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    busy_o      = (state_q == S_RUN);
    out_valid_o = (state_q == S_DONE);
    sum_o       = sum_q;
    cout_o      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_o       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): expected results are queued at
// operand acceptance and popped when out_valid appears.
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .busy_o      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Accept operands at the next edge; inputs change on negedges only
  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sb_q.push_back(model(x, y, ci));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency/busy/result, hold in DONE, then release
  task automatic run_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                         input bit junk, input int hold);
    int cyc;
    int busy_cnt;
    exp_t e;
    logic [WIDTH-1:0] held_sum;
    accept(x, y, ci);
    cyc = 0;
    busy_cnt = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) busy_cnt++;
      if (junk) begin
        in_valid = ~in_valid;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(WIDTH));
    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("sum", 32'(sum), 32'(e.sum));
    check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
    held_sum = sum;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(held_sum));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("idle_sum_held", 32'(sum), 32'(e.sum));
    check("idle_cout_held", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf_cleared", 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // out_ready outside DONE must be ignored
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready_ignored", 32'(in_ready), 32'd1);

    run_add(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    run_add(8'hFF, 8'h00, 1'b1, 1'b0, 0);
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    run_add(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_add(8'h80, 8'h80, 1'b0, 1'b0, 0);
    run_add(8'hA5, 8'h5A, 1'b1, 1'b0, 5);
    run_add(8'h3C, 8'h4B, 1'b0, 1'b1, 0);
    run_add(8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Reset while processing bit 3: partial result discarded
    accept(8'hC3, 8'h5A, 1'b1);
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);

    run_add(8'h12, 8'h34, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
